// File: rtl/player_input_sched_pkg.sv
// Shared key codes, fire FSM states and direction type for the two-player keyboard path.
package game_keys_pkg;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_ENTER = 8'h28;

   typedef enum logic {
      READY = 1'b0,
      COOL  = 1'b1
   } fire_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
   } dir_t;

   // A key is pressed if either slot carries its code; a code in both slots is one press.
   function automatic logic key_pressed(input logic [15:0] keycode, input logic [7:0] code);
      return (keycode[15:8] == code) || (keycode[7:0] == code);
   endfunction

endpackage

// File: rtl/player_input_sched_if.sv
// Keycode input and per-player command outputs of the input scheduler.
interface player_input_sched_if;

   logic        frame_clk;
   logic [15:0] keycode;
   logic [3:0]  p1_dir;
   logic [3:0]  p2_dir;
   logic        p1_fire;
   logic        p2_fire;
   logic        p1_ready;
   logic        p2_ready;

   modport master (
      output frame_clk, keycode,
      input  p1_dir, p2_dir, p1_fire, p2_fire, p1_ready, p2_ready
   );

   modport slave (
      input  frame_clk, keycode,
      output p1_dir, p2_dir, p1_fire, p2_fire, p1_ready, p2_ready
   );

endinterface

// File: rtl/player_input_sched_cmd.sv
// One player's command path: slot decode, opposing-axis cancel, rate-limited fire FSM.
module player_cmd
   import game_keys_pkg::*;
#(
   parameter logic [7:0]  UP_CODE         = KEY_W,
   parameter logic [7:0]  DN_CODE         = KEY_S,
   parameter logic [7:0]  LT_CODE         = KEY_A,
   parameter logic [7:0]  RT_CODE         = KEY_D,
   parameter logic [7:0]  FIRE_CODE       = KEY_SPACE,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        tick,
   input  logic [15:0] keycode,
   output dir_t        dir,
   output logic        fire,
   output logic        ready
);

   localparam bit         HAS_COOL  = (COOLDOWN_FRAMES != 32'd0);
   localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES);

   logic        up_s;
   logic        down_s;
   logic        left_s;
   logic        right_s;
   logic        fire_key_s;
   dir_t        dir_s;

   fire_state_t state_r;
   logic [7:0]  cnt_r;
   logic        fire_prev_r;
   logic        fire_r;
   dir_t        dir_r;

   // Decode both slots and cancel an axis whose two opposing keys are both held.
   always_comb begin
      up_s        = key_pressed(keycode, UP_CODE);
      down_s      = key_pressed(keycode, DN_CODE);
      left_s      = key_pressed(keycode, LT_CODE);
      right_s     = key_pressed(keycode, RT_CODE);
      fire_key_s  = key_pressed(keycode, FIRE_CODE);
      dir_s.up    = up_s & ~down_s;
      dir_s.down  = down_s & ~up_s;
      dir_s.left  = left_s & ~right_s;
      dir_s.right = right_s & ~left_s;
   end

   // Frame-tick state update: direction sample, press-edge fire and cooldown countdown.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= READY;
         cnt_r       <= 8'd0;
         fire_prev_r <= 1'b0;
         fire_r      <= 1'b0;
         dir_r       <= 4'b0000;
      end else begin
         fire_r <= 1'b0;
         if (tick) begin
            dir_r       <= dir_s;
            fire_prev_r <= fire_key_s;
            case (state_r)
               READY: begin
                  if (fire_key_s && !fire_prev_r) begin
                     fire_r <= 1'b1;
                     if (HAS_COOL) begin
                        cnt_r   <= COOL_INIT;
                        state_r <= COOL;
                     end
                  end
               end
               COOL: begin
                  // Presses are discarded here; cnt never drops below 1 in COOL.
                  if (cnt_r == 8'd1) begin
                     state_r <= READY;
                     cnt_r   <= 8'd0;
                  end else begin
                     cnt_r <= cnt_r - 8'd1;
                  end
               end
               default: begin
                  state_r <= READY;
                  cnt_r   <= 8'd0;
               end
            endcase
         end
      end
   end

   assign dir   = dir_r;
   assign fire  = fire_r;
   assign ready = (state_r == READY);

endmodule

// File: rtl/player_input_sched.sv
// Frame-rate keyboard command scheduler: detects the frame tick and feeds two player_cmd blocks.
module player_input_sched
   import game_keys_pkg::*;
#(
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input logic                 Clk,
   input logic                 Reset,
   player_input_sched_if.slave bus
);

   logic frame_clk_d_r;
   logic tick_s;
   dir_t p1_dir_s;
   dir_t p2_dir_s;
   logic p1_fire_s;
   logic p2_fire_s;
   logic p1_ready_s;
   logic p2_ready_s;

   // Delayed frame strobe; resets high so a strobe already high at release is not a tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_d_r <= 1'b1;
      end else begin
         frame_clk_d_r <= bus.frame_clk;
      end
   end

   assign tick_s = bus.frame_clk & ~frame_clk_d_r;

   player_cmd #(
      .UP_CODE         (KEY_W),
      .DN_CODE         (KEY_S),
      .LT_CODE         (KEY_A),
      .RT_CODE         (KEY_D),
      .FIRE_CODE       (KEY_SPACE),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) u_p1 (
      .Clk     (Clk),
      .Reset   (Reset),
      .tick    (tick_s),
      .keycode (bus.keycode),
      .dir     (p1_dir_s),
      .fire    (p1_fire_s),
      .ready   (p1_ready_s)
   );

   player_cmd #(
      .UP_CODE         (KEY_UP),
      .DN_CODE         (KEY_DOWN),
      .LT_CODE         (KEY_LEFT),
      .RT_CODE         (KEY_RIGHT),
      .FIRE_CODE       (KEY_ENTER),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) u_p2 (
      .Clk     (Clk),
      .Reset   (Reset),
      .tick    (tick_s),
      .keycode (bus.keycode),
      .dir     (p2_dir_s),
      .fire    (p2_fire_s),
      .ready   (p2_ready_s)
   );

   assign bus.p1_dir   = p1_dir_s;
   assign bus.p2_dir   = p2_dir_s;
   assign bus.p1_fire  = p1_fire_s;
   assign bus.p2_fire  = p2_fire_s;
   assign bus.p1_ready = p1_ready_s;
   assign bus.p2_ready = p2_ready_s;

endmodule

// File: tb/tb_player_input_sched.sv
// Directed bench: two schedulers (cooldown 8 and 0) against a frame-level reference model.
module tb_player_input_sched;

   typedef struct packed {
      logic [3:0] p1_dir;
      logic [3:0] p2_dir;
      logic       p1_fire;
      logic       p2_fire;
      logic       p1_ready;
      logic       p2_ready;
   } outs_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic [15:0] keycode;

   int total = 0;
   int bad   = 0;

   outs_t exp_q[$];

   logic [3:0] m_dir   [2][2];
   logic       m_fire  [2][2];
   logic       m_ready [2][2];
   logic       m_prev  [2][2];
   int         m_cnt   [2][2];
   int         cd      [2];
   logic [7:0] codes   [2][5];

   logic fire8_p1, fire8_p2, ready8_p1, fire0_p1;

   player_input_sched_if bus8 ();
   player_input_sched_if bus0 ();

   assign bus8.frame_clk = frame_clk;
   assign bus8.keycode   = keycode;
   assign bus0.frame_clk = frame_clk;
   assign bus0.keycode   = keycode;

   player_input_sched #(.COOLDOWN_FRAMES(8)) u_dut8 (.Clk(Clk), .Reset(Reset), .bus(bus8));
   player_input_sched #(.COOLDOWN_FRAMES(0)) u_dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));

   always #5 Clk = ~Clk;

   function automatic logic hit(input logic [15:0] kc, input logic [7:0] c);
      return (kc[15:8] == c) || (kc[7:0] == c);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            m_dir[d][p]   = 4'b0000;
            m_fire[d][p]  = 1'b0;
            m_ready[d][p] = 1'b1;
            m_prev[d][p]  = 1'b0;
            m_cnt[d][p]   = 0;
         end
      end
   endtask

   task automatic model_tick(input logic [15:0] kc);
      logic [1:0] v, h;
      logic       pr;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            v = {hit(kc, codes[p][0]), hit(kc, codes[p][1])};
            h = {hit(kc, codes[p][2]), hit(kc, codes[p][3])};
            if (v == 2'b11) v = 2'b00;
            if (h == 2'b11) h = 2'b00;
            m_dir[d][p] = {v, h};
            pr = hit(kc, codes[p][4]);
            m_fire[d][p] = 1'b0;
            if (m_ready[d][p]) begin
               if (pr && !m_prev[d][p]) begin
                  m_fire[d][p] = 1'b1;
                  if (cd[d] > 0) begin
                     m_ready[d][p] = 1'b0;
                     m_cnt[d][p]   = cd[d];
                  end
               end
            end else begin
               if (m_cnt[d][p] == 1) m_ready[d][p] = 1'b1;
               m_cnt[d][p] = m_cnt[d][p] - 1;
            end
            m_prev[d][p] = pr;
         end
      end
   endtask

   function automatic outs_t model_out(input int d, input logic with_fire);
      outs_t o;
      o.p1_dir   = m_dir[d][0];
      o.p2_dir   = m_dir[d][1];
      o.p1_fire  = with_fire & m_fire[d][0];
      o.p2_fire  = with_fire & m_fire[d][1];
      o.p1_ready = m_ready[d][0];
      o.p2_ready = m_ready[d][1];
      return o;
   endfunction

   task automatic push_exp(input logic with_fire);
      exp_q.push_back(model_out(0, with_fire));
      exp_q.push_back(model_out(1, with_fire));
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      outs_t e, o8, o0;
      o8 = {bus8.p1_dir, bus8.p2_dir, bus8.p1_fire, bus8.p2_fire, bus8.p1_ready, bus8.p2_ready};
      o0 = {bus0.p1_dir, bus0.p2_dir, bus0.p1_fire, bus0.p2_fire, bus0.p1_ready, bus0.p2_ready};
      if (exp_q.size() < 2) begin
         total++;
         bad++;
         $error("FAIL %s observed=queue_size_%0d expected=2", tag, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         check({tag, "_cd8"}, 32'(o8), 32'(e));
         e = exp_q.pop_front();
         check({tag, "_cd0"}, 32'(o0), 32'(e));
      end
   endtask

   // One frame: rising strobe with kc, tick check, hold check, then a low phase with junk keycode.
   task automatic frame(input logic [15:0] kc, input string tag);
      @(negedge Clk);
      frame_clk = 1'b1;
      keycode   = kc;
      model_tick(kc);
      push_exp(1'b1);
      push_exp(1'b0);
      @(negedge Clk);
      fire8_p1  = bus8.p1_fire;
      fire8_p2  = bus8.p2_fire;
      ready8_p1 = bus8.p1_ready;
      fire0_p1  = bus0.p1_fire;
      check_outs({tag, "_tick"});
      @(negedge Clk);
      check_outs({tag, "_hold"});
      frame_clk = 1'b0;
      keycode   = 16'h1A2C;
      push_exp(1'b0);
      @(negedge Clk);
      check_outs({tag, "_low"});
   endtask

   initial begin
      int pulses8, pulses0, lowcnt;
      cd[0] = 8;
      cd[1] = 0;
      codes[0] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C};
      codes[1] = '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h28};

      // 1: reset with strobe held high; no tick after release
      Reset     = 1'b1;
      frame_clk = 1'b1;
      keycode   = 16'h1A52;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         push_exp(1'b0);
         @(negedge Clk);
         check_outs("t1_post_reset");
      end
      check("t1_ready_p1", 32'(bus8.p1_ready), 32'd1);
      frame_clk = 1'b0;
      @(negedge Clk);

      // 2: up for both players
      frame(16'h1A52, "t2");
      check("t2_p1_dir", 32'(bus8.p1_dir), 32'h8);
      check("t2_p2_dir", 32'(bus8.p2_dir), 32'h8);

      // 3: axis cancel
      frame(16'h1A16, "t3_ws");
      check("t3_ws_p1_dir", 32'(bus8.p1_dir), 32'h0);
      frame(16'h0407, "t3_ad");
      check("t3_ad_p1_dir", 32'(bus8.p1_dir), 32'h0);
      frame(16'h1A04, "t3_wa");
      check("t3_wa_p1_dir", 32'(bus8.p1_dir), 32'hA);
      frame(16'h5251, "t3_p2ud");
      frame(16'h5250, "t3_p2ul");
      check("t3_p2ul_dir", 32'(bus8.p2_dir), 32'hA);

      // 4: space held 20 frames -> one pulse, ready low for 8 ticks
      pulses8 = 0;
      pulses0 = 0;
      lowcnt  = 0;
      for (int i = 0; i < 20; i++) begin
         frame(16'h2C00, "t4_hold");
         pulses8 += int'(fire8_p1);
         pulses0 += int'(fire0_p1);
         if (!ready8_p1) lowcnt++;
      end
      check("t4_pulses_cd8", 32'(pulses8), 32'd1);
      check("t4_pulses_cd0", 32'(pulses0), 32'd1);
      check("t4_ready_low_ticks", 32'(lowcnt), 32'd8);
      frame(16'h0000, "t4_release");
      frame(16'h002C, "t4_repress");
      check("t4_second_pulse", 32'(fire8_p1), 32'd1);

      // 5: both players fire on the same tick
      for (int i = 0; i < 9; i++) frame(16'h0000, "t5_idle");
      frame(16'h2C28, "t5_both");
      check("t5_p1_fire", 32'(fire8_p1), 32'd1);
      check("t5_p2_fire", 32'(fire8_p2), 32'd1);

      // 6: reset in the middle of cooldown, key held across reset
      for (int i = 0; i < 9; i++) frame(16'h0000, "t6_idle");
      frame(16'h2C00, "t6_fire");
      for (int i = 0; i < 3; i++) frame(16'h2C00, "t6_cool");
      check("t6_ready_before", 32'(bus8.p1_ready), 32'd0);
      @(negedge Clk);
      Reset   = 1'b1;
      keycode = 16'h2C00;
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      push_exp(1'b0);
      check_outs("t6_after_reset");
      check("t6_ready_after", 32'(bus8.p1_ready), 32'd1);
      frame(16'h2C00, "t6_held");
      check("t6_held_fires", 32'(fire8_p1), 32'd1);

      // cooldown 0: every press edge fires
      frame(16'h0000, "t6_cd0_rel1");
      frame(16'h2C00, "t6_cd0_p1");
      check("t6_cd0_fire1", 32'(fire0_p1), 32'd1);
      frame(16'h0000, "t6_cd0_rel2");
      frame(16'h2C00, "t6_cd0_p2");
      check("t6_cd0_fire2", 32'(fire0_p1), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
